key_filter_array: RTL

Parametrised multi-channel key debouncer with press/release event pulses and optional long-press detection. Each of `N_KEYS` raw inputs is synchronised, filtered by a per-channel stability counter, and presented as a clean level plus single-cycle edge events. Sits between board push-buttons and the game/control FSMs, replacing per-key single-channel debouncers.

---
 rtl/key_filter_pkg.sv | 22 ++
 rtl/key_filter_array_if.sv | 27 ++
 rtl/key_filter_chan.sv | 95 +++++++++
 rtl/key_filter_array.sv | 53 +++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// Shared width helpers, default timing constants and the per-channel event bundle
// for the key_filter_array debouncer.
package key_filter_pkg;

  localparam int unsigned DEF_STABLE_CYCLES = 16;
  localparam int unsigned DEF_LONG_CYCLES   = 1024;

  typedef struct packed {
    logic press;
    logic rel;
    logic long_press;
  } key_evt_t;

  function automatic int unsigned cnt_w(input int unsigned stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

  function automatic int unsigned hold_w(input int unsigned long_cycles);
    return $clog2(long_cycles + 1);
  endfunction

endpackage

// File: rtl/key_filter_array_if.sv
// Key bundle between push-buttons and consumers; the release pulse is named
// key_release because 'release' is a reserved SystemVerilog keyword.
interface key_filter_array_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_in;
  logic [N_KEYS-1:0] key_out;
  logic [N_KEYS-1:0] press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] long_press;

  modport master (
    output key_in,
    input  key_out,
    input  press,
    input  key_release,
    input  long_press
  );

  modport slave (
    input  key_in,
    output key_out,
    output press,
    output key_release,
    output long_press
  );
endinterface

// File: rtl/key_filter_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, press/release pulses
// and, with KEY_FILTER_LONG_PRESS_EN defined, a saturating long-press hold counter.
module key_filter_chan
  import key_filter_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic        RESET_LEVEL   = 1'b0
`ifdef KEY_FILTER_LONG_PRESS_EN
  ,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES
`endif
) (
  input  logic     clk,
  input  logic     nrst,
  input  logic     i_key,
  output logic     o_key,
  output key_evt_t o_evt
);

  localparam int unsigned      CNT_W    = cnt_w(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_key;
  logic             r_press;
  logic             r_rel;
  logic [CNT_W-1:0] r_cnt;
  logic             w_long;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sync1 <= RESET_LEVEL;
      r_sync2 <= RESET_LEVEL;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Any sample agreeing with the current level restarts the run of disagreeing samples.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_key   <= RESET_LEVEL;
      r_cnt   <= '0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      if (r_sync2 == r_key) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_key   <= r_sync2;
        r_cnt   <= '0;
        r_press <= r_sync2;
        r_rel   <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef KEY_FILTER_LONG_PRESS_EN
  localparam int unsigned       HOLD_W   = hold_w(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

  logic [HOLD_W-1:0] r_hold;
  logic              r_long;

  // Saturating at HOLD_MAX is what limits long_press to one pulse per press.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else if (!r_key) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else if (r_hold != HOLD_MAX) begin
      r_hold <= r_hold + HOLD_W'(1);
      r_long <= (r_hold == (HOLD_MAX - HOLD_W'(1)));
    end else begin
      r_long <= 1'b0;
    end
  end

  assign w_long = r_long;
`else
  assign w_long = 1'b0;
`endif

  assign o_key = r_key;
  assign o_evt = '{press: r_press, rel: r_rel, long_press: w_long};

endmodule

// File: rtl/key_filter_array.sv
// N_KEYS independent debounce channels behind one key bundle interface.
// Long-press detection is built only when KEY_FILTER_LONG_PRESS_EN is defined.
module key_filter_array
  import key_filter_pkg::*;
#(
  parameter int          N_KEYS        = 4,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input logic               clk,
  input logic               nrst,
  key_filter_array_if.slave bus
);

  logic [N_KEYS-1:0] w_key_out;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;
  logic [N_KEYS-1:0] w_long;

  if (N_KEYS < 1 || N_KEYS > 32 || STABLE_CYCLES < 2 || LONG_CYCLES <= STABLE_CYCLES) begin : g_bad_cfg
    $error("key_filter_array: unsupported parameter combination");
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_evt_t w_evt;

    key_filter_chan #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_LEVEL   (RESET_LEVEL)
`ifdef KEY_FILTER_LONG_PRESS_EN
      ,
      .LONG_CYCLES   (LONG_CYCLES)
`endif
    ) u_chan (
      .clk   (clk),
      .nrst  (nrst),
      .i_key (bus.key_in[g]),
      .o_key (w_key_out[g]),
      .o_evt (w_evt)
    );

    assign w_press[g]   = w_evt.press;
    assign w_release[g] = w_evt.rel;
    assign w_long[g]    = w_evt.long_press;
  end

  assign bus.key_out     = w_key_out;
  assign bus.press       = w_press;
  assign bus.key_release = w_release;
  assign bus.long_press  = w_long;

endmodule
